// File: rtl/fll_lock_mon_if.sv
// FLL lock monitor signal bundle: enable/raw lock in, supervisor outputs back.
// slave is the monitor side, master is the controlling side.
interface fll_lock_mon_if #(
  parameter int unsigned EVT_W = 8
);
  logic             en;
  logic             lock_in;
  logic             cfgreq_o;
  logic             bypass_o;
  logic             locked_o;
  logic             fail_o;
  logic [EVT_W-1:0] loss_cnt_o;
  logic [2:0]       state_o;

  modport master (
    output en,
    output lock_in,
    input  cfgreq_o,
    input  bypass_o,
    input  locked_o,
    input  fail_o,
    input  loss_cnt_o,
    input  state_o
  );

  modport slave (
    input  en,
    input  lock_in,
    output cfgreq_o,
    output bypass_o,
    output locked_o,
    output fail_o,
    output loss_cnt_o,
    output state_o
  );
endinterface

// File: rtl/fll_lock_mon.sv
// FLL bring-up / lock supervisor on the reference clock.
// Synchronises and filters the raw FLL lock, issues config requests with timeout/retry,
// holds the FLL in bypass until lock is stable and counts lock-loss events.
// Build option: define FLL_LOCK_MON_AUTORELOCK_EN to relock (REQ, fresh retry budget)
// after lock loss instead of parking in FAIL.
module fll_lock_mon #(
  parameter int unsigned LOCK_FILT = 8,
  parameter int unsigned TMO_W     = 16,
  parameter int unsigned TMO       = 50000,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned EVT_W     = 8
) (
  input  logic          ref_clk,
  input  logic          rst,
  fll_lock_mon_if.slave mon_if
);

  localparam int unsigned      FILT_W    = $clog2(LOCK_FILT + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO - 1);
  localparam logic [3:0]        RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StReq    = 3'd1,
    StWait   = 3'd2,
    StLocked = 3'd3,
    StFail   = 3'd4
  } state_e;

  logic              r_sync1;
  logic              r_sync2;
  logic [FILT_W-1:0] r_filt_cnt;
  logic              r_lock_f;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [TMO_W-1:0]  r_tmo;
  logic [TMO_W-1:0]  w_tmo_nxt;
  logic [3:0]        r_retry;
  logic [3:0]        w_retry_nxt;
  logic [EVT_W-1:0]  r_loss;
  logic [EVT_W-1:0]  w_loss_nxt;

  logic              r_cfgreq;
  logic              r_bypass;
  logic              r_locked;
  logic              r_fail;

  // Two-flop synchroniser for the asynchronous raw lock.
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= mon_if.lock_in;
      r_sync2 <= r_sync1;
    end
  end

  // Lock filter: lock_f follows lock_s only after LOCK_FILT consecutive mismatching samples.
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      r_filt_cnt <= '0;
      r_lock_f   <= 1'b0;
    end else if (r_sync2 != r_lock_f) begin
      if (r_filt_cnt == FILT_LAST) begin
        r_lock_f   <= r_sync2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end else begin
      r_filt_cnt <= '0;
    end
  end

  // Next-state and counter update; en=0 overrides everything and returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_tmo_nxt   = r_tmo;
    w_retry_nxt = r_retry;
    w_loss_nxt  = r_loss;
    if (!mon_if.en) begin
      w_state_nxt = StIdle;
      w_tmo_nxt   = '0;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        StIdle: begin
          w_state_nxt = StReq;
          w_retry_nxt = '0;
        end
        StReq: begin
          w_state_nxt = StWait;
          w_retry_nxt = r_retry + 1'b1;
          w_tmo_nxt   = '0;
        end
        StWait: begin
          w_tmo_nxt = r_tmo + 1'b1;
          // Lock is checked first so it wins a same-cycle timeout.
          if (r_lock_f) begin
            w_state_nxt = StLocked;
          end else if (r_tmo == TMO_LAST) begin
            w_state_nxt = (r_retry < RETRY_MAX) ? StReq : StFail;
          end
        end
        StLocked: begin
          if (!r_lock_f) begin
            if (r_loss != '1) begin
              w_loss_nxt = r_loss + 1'b1;
            end
`ifdef FLL_LOCK_MON_AUTORELOCK_EN
            w_state_nxt = StReq;
            w_retry_nxt = '0;
`else
            w_state_nxt = StFail;
`endif
          end
        end
        StFail: begin
          w_state_nxt = StFail;
        end
        default: begin
          w_state_nxt = StIdle;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_tmo   <= '0;
      r_retry <= '0;
      r_loss  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmo   <= w_tmo_nxt;
      r_retry <= w_retry_nxt;
      r_loss  <= w_loss_nxt;
    end
  end

  // Outputs registered from the next state so they change on the same edge as the state.
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      r_cfgreq <= 1'b0;
      r_bypass <= 1'b1;
      r_locked <= 1'b0;
      r_fail   <= 1'b0;
    end else begin
      r_cfgreq <= (w_state_nxt == StReq);
      r_bypass <= (w_state_nxt != StLocked);
      r_locked <= (w_state_nxt == StLocked);
      r_fail   <= (w_state_nxt == StFail);
    end
  end

  assign mon_if.cfgreq_o   = r_cfgreq;
  assign mon_if.bypass_o   = r_bypass;
  assign mon_if.locked_o   = r_locked;
  assign mon_if.fail_o     = r_fail;
  assign mon_if.loss_cnt_o = r_loss;
  assign mon_if.state_o    = r_state;

endmodule
